main_controller: RTL
====================

MAIN_CONTROLLER -- requirements
Module: main_controller

Interface
REQ-001 SHALL have ports: clk input 1 (sole clock, rising edge); reset input 1 (synchronous, active-high).
REQ-002 SHALL have ports: op input 7, func3 input 3, func7b5 input 1 (from instruction register); Zero, Negative, Carry, Overflow input 1 each (ALU flags); mem_ready input 1 (memory access completes this cycle).
REQ-003 SHALL have ports: RegWrite, IRWrite, AdrSrc, PCWrite, MemWrite output 1 each; ResultSrc, ALUSrcA, ALUSrcB output 2 each; ImmSrc, ALUControl output 3 each; illegal_instr output 1.
REQ-004 Mux codes SHALL be: ALUSrcA 0=PC, 1=OldPC, 2=A; ALUSrcB 0=WriteData, 1=ImmExt, 2=4; ResultSrc 0=ALUOut, 1=Data, 2=ALUResult; AdrSrc 0=PC, 1=Result.
REQ-005 ImmSrc SHALL be 0=I, 1=S, 2=B, 3=J, 4=U; ALUControl SHALL be 0=ADD, 1=SUB, 2=AND, 3=OR, 4=XOR, 5=SLT, 6=SLTU, 7=PASS_B.

Function
REQ-006 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR1, JALR2, LUI, HALT; outputs are decoded from state, plus the mem_ready gating in REQ-007/REQ-010.
REQ-007 FETCH: AdrSrc=0, ALUSrcA=0, ALUSrcB=2, ADD, ResultSrc=2; IRWrite=PCWrite=mem_ready; stays in FETCH until mem_ready=1, then goes to DECODE.
REQ-008 DECODE: ALUSrcA=1, ALUSrcB=1, ADD (ALUOut=OldPC+imm); ImmSrc=B for op 1100011, J for 1101111, U for 0010111, else I.
REQ-009 DECODE next state: 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALR1; 0110111 -> LUI; 0010111 -> ALUWB; any other op -> illegal per REQ-018.
REQ-010 MEMADR: ALUSrcA=2, ALUSrcB=1, ADD, ImmSrc=I (load) or S (store), then MEMREAD (load) or MEMWRITE (store). MEMREAD: AdrSrc=1, ResultSrc=0; holds until mem_ready, then MEMWB. MEMWB: ResultSrc=1, RegWrite=1 -> FETCH. MEMWRITE: AdrSrc=1, ResultSrc=0, MemWrite=1 held until mem_ready -> FETCH.
REQ-011 EXECR: ALUSrcA=2, ALUSrcB=0. EXECI: ALUSrcA=2, ALUSrcB=1, ImmSrc=I. Both go to ALUWB. ALUWB: ResultSrc=0, RegWrite=1 -> FETCH.
REQ-012 ALU decode for EXECR/EXECI by func3: 000 ADD (SUB if EXECR and func7b5=1), 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND; func3 001/101 (shifts) -> illegal per REQ-018.
REQ-013 BRANCH: ALUSrcA=2, ALUSrcB=0, SUB, ResultSrc=0; PCWrite=taken -> FETCH. taken: beq Zero; bne !Zero; blt Negative^Overflow; bge !(Negative^Overflow); bltu !Carry; bgeu Carry (Carry=1 means no borrow). func3 010/011 -> illegal.
REQ-014 JAL: ALUSrcA=1, ALUSrcB=2, ADD, ResultSrc=0, PCWrite=1 -> ALUWB (rd=OldPC+4).
REQ-015 JALR1: ALUSrcA=2, ALUSrcB=1, ImmSrc=I, ADD -> JALR2. JALR2: ALUSrcA=1, ALUSrcB=2, ADD, ResultSrc=0, PCWrite=1 -> ALUWB. Target LSB is not cleared.
REQ-016 LUI: ALUSrcB=1, ImmSrc=U, PASS_B -> ALUWB.
REQ-017 Strobes (RegWrite, IRWrite, PCWrite, MemWrite) SHALL be 0 in every state or condition not listed above; unlisted mux fields SHALL be 0.

Reset
REQ-018 (illegal handling, see Configuration) Illegal op/func3 SHALL take the path defined by TRAP_ILLEGAL_EN.
REQ-019 reset=1 at a clock edge SHALL set the state to FETCH from any state, including mid-MEMWRITE or mid-wait; while reset=1, all strobes SHALL be 0 and illegal_instr SHALL be 0.
REQ-020 The first cycle after reset deassertion SHALL be FETCH with PC fetch outputs active.

Configuration
REQ-021 TRAP_ILLEGAL_EN defined: illegal -> HALT; HALT drives all strobes 0, illegal_instr=1, and is left only by reset.
REQ-022 TRAP_ILLEGAL_EN undefined: illegal -> FETCH (NOP); illegal_instr is tied 0 and HALT is not implemented.

Verification
REQ-023 add x3,x1,x2 (0x002081B3), mem_ready=1 -> FETCH,DECODE,EXECR,ALUWB; ALUControl=0 in EXECR; RegWrite=1 only in ALUWB; 4 cycles.
REQ-024 lw with mem_ready low 3 cycles in MEMREAD -> MEMREAD held 4 cycles, AdrSrc=1 throughout; MEMWB RegWrite=1, ResultSrc=1.
REQ-025 beq with Zero=1 -> PCWrite=1 in BRANCH; bltu with Carry=1 -> PCWrite=0; DECODE ImmSrc=2.
REQ-026 jal -> JAL PCWrite=1 then ALUWB RegWrite=1; jalr -> JALR1,JALR2,ALUWB, PCWrite only in JALR2.
REQ-027 Opcode 0x7F: with TRAP_ILLEGAL_EN -> HALT, illegal_instr=1 until reset; without -> next state FETCH, no strobes.
REQ-028 reset asserted during MEMWRITE with mem_ready=0 -> next cycle FETCH, MemWrite=0 while reset high.

Source files
------------

// File: rtl/main_controller.sv
// Multicycle RV32I-subset control FSM: Moore outputs per state, with FETCH/MEMWRITE handshakes on mem_ready.
// Optional build macro TRAP_ILLEGAL_EN: illegal instructions park in HALT instead of falling back to FETCH.
module main_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic       func7b5,
  input  logic       Zero,
  input  logic       Negative,
  input  logic       Carry,
  input  logic       Overflow,
  input  logic       mem_ready,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       illegal_instr
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd4;
  localparam logic [2:0] ALU_SLT  = 3'd5;
  localparam logic [2:0] ALU_SLTU = 3'd6;
  localparam logic [2:0] ALU_PASS = 3'd7;

  localparam logic [1:0] SRCA_PC = 2'd0, SRCA_OLDPC = 2'd1, SRCA_A = 2'd2;
  localparam logic [1:0] SRCB_WD = 2'd0, SRCB_IMM = 2'd1, SRCB_FOUR = 2'd2;
  localparam logic [1:0] RES_ALUOUT = 2'd0, RES_DATA = 2'd1, RES_ALURESULT = 2'd2;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
    ALUWB, BRANCH, JAL, JALR1, JALR2, LUI
`ifdef TRAP_ILLEGAL_EN
    , HALT
`endif
  } state_t;

`ifdef TRAP_ILLEGAL_EN
  localparam state_t TRAP_STATE = HALT;
`else
  localparam state_t TRAP_STATE = FETCH;
`endif

  state_t     state_q, state_d;
  logic       illegalOp;
  logic       branchTaken;
  logic [2:0] aluSel;

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Legality is judged once in DECODE so the execute states never see a bad func3.
  always_comb begin
    illegalOp = 1'b0;
    case (op)
      OP_R, OP_I: illegalOp = (func3 == 3'b001) || (func3 == 3'b101);
      OP_BR:      illegalOp = (func3 == 3'b010) || (func3 == 3'b011);
      OP_LOAD, OP_STORE, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: illegalOp = 1'b0;
      default:    illegalOp = 1'b1;
    endcase
  end

  always_comb begin
    aluSel = ALU_ADD;
    case (func3)
      3'b000:  aluSel = (state_q == EXECR && func7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  aluSel = ALU_SLT;
      3'b011:  aluSel = ALU_SLTU;
      3'b100:  aluSel = ALU_XOR;
      3'b110:  aluSel = ALU_OR;
      3'b111:  aluSel = ALU_AND;
      default: aluSel = ALU_ADD;
    endcase
  end

  // Carry=1 after SUB means no borrow, i.e. rs1 >= rs2 unsigned.
  always_comb begin
    branchTaken = 1'b0;
    case (func3)
      3'b000:  branchTaken = Zero;
      3'b001:  branchTaken = !Zero;
      3'b100:  branchTaken = Negative ^ Overflow;
      3'b101:  branchTaken = !(Negative ^ Overflow);
      3'b110:  branchTaken = !Carry;
      3'b111:  branchTaken = Carry;
      default: branchTaken = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    RegWrite      = 1'b0;
    IRWrite       = 1'b0;
    AdrSrc        = 1'b0;
    PCWrite       = 1'b0;
    MemWrite      = 1'b0;
    ResultSrc     = RES_ALUOUT;
    ALUSrcA       = SRCA_PC;
    ALUSrcB       = SRCB_WD;
    ImmSrc        = IMM_I;
    ALUControl    = ALU_ADD;
    illegal_instr = 1'b0;
    case (state_q)
      FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_BR:    ImmSrc = IMM_B;
          OP_JAL:   ImmSrc = IMM_J;
          OP_AUIPC: ImmSrc = IMM_U;
          default:  ImmSrc = IMM_I;
        endcase
        if (illegalOp) state_d = TRAP_STATE;
        else begin
          case (op)
            OP_LOAD, OP_STORE: state_d = MEMADR;
            OP_R:              state_d = EXECR;
            OP_I:              state_d = EXECI;
            OP_BR:             state_d = BRANCH;
            OP_JAL:            state_d = JAL;
            OP_JALR:           state_d = JALR1;
            OP_LUI:            state_d = LUI;
            default:           state_d = ALUWB;
          endcase
        end
      end
      MEMADR: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
        if (op == OP_STORE) begin
          ImmSrc  = IMM_S;
          state_d = MEMWRITE;
        end else begin
          state_d = MEMREAD;
        end
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
        state_d   = FETCH;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) state_d = FETCH;
      end
      EXECR: begin
        ALUSrcA    = SRCA_A;
        ALUControl = aluSel;
        state_d    = ALUWB;
      end
      EXECI: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_IMM;
        ALUControl = aluSel;
        state_d    = ALUWB;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        state_d  = FETCH;
      end
      BRANCH: begin
        ALUSrcA    = SRCA_A;
        ALUControl = ALU_SUB;
        PCWrite    = branchTaken;
        state_d    = FETCH;
      end
      JAL, JALR2: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
        state_d = ALUWB;
      end
      JALR1: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
        state_d = JALR2;
      end
      LUI: begin
        ALUSrcB    = SRCB_IMM;
        ImmSrc     = IMM_U;
        ALUControl = ALU_PASS;
        state_d    = ALUWB;
      end
`ifdef TRAP_ILLEGAL_EN
      HALT: begin
        illegal_instr = 1'b1;
        state_d       = HALT;
      end
`endif
      default: state_d = FETCH;
    endcase
    // Reset wins over whatever state the register currently holds.
    if (reset) begin
      RegWrite      = 1'b0;
      IRWrite       = 1'b0;
      PCWrite       = 1'b0;
      MemWrite      = 1'b0;
      illegal_instr = 1'b0;
    end
  end

endmodule
